// File: rtl/k_12_sq_seq.sv
// Sequential FP16 squarer: shift-add significand multiply, one multiplier bit per cycle,
// fixed 12-cycle latency from the accepting edge to the done pulse.
module k_12_sq_seq #(
    parameter bit ROUND = 1'b0,
    parameter bit SAT   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] in,
    output logic [15:0] out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, MUL, NORM} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [10:0] sig_q, sig_d;
    logic [4:0]  exp_q, exp_d;
    logic [21:0] acc_q, acc_d;
    logic [15:0] out_q, out_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // p holds product bits [21:9]; everything below bit 9 can never reach the result.
    function automatic logic [15:0] sq_result(input logic [12:0] p,
                                              input logic [4:0]  e_in,
                                              input logic [9:0]  m_in);
        logic signed [6:0] e;
        logic [9:0]        m;
        logic              rb;
        logic [10:0]       s;
        e = $signed({1'b0, e_in, 1'b0}) - 7'sd15;
        if (p[12]) begin
            e  = e + 7'sd1;
            m  = p[11:2];
            rb = p[1];
        end else begin
            m  = p[10:1];
            rb = p[0];
        end
        s = {1'b0, m} + {10'b0, rb & ROUND};
        if (s[10]) begin
            m = 10'd0;
            e = e + 7'sd1;
        end else begin
            m = s[9:0];
        end
        if (e_in == 5'd31 && m_in != 10'd0) sq_result = 16'h7E00;
        else if (e_in == 5'd31)             sq_result = 16'h7C00;
        else if (e_in == 5'd0)              sq_result = 16'h0000;
        else if (e >= 7'sd31)               sq_result = SAT ? 16'h7BFF : 16'h7C00;
        else if (e <= 7'sd0)                sq_result = 16'h0000;
        else                                sq_result = {1'b0, e[4:0], m};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = MUL;
            MUL:     if (cnt_q == 4'd10) state_d = NORM;
            NORM:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        sig_d  = sig_q;
        exp_d  = exp_q;
        acc_d  = acc_q;
        out_d  = out_q;
        busy_d = busy_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = en;
                if (en) begin
                    sig_d = {1'b1, in[9:0]};
                    exp_d = in[14:10];
                    acc_d = 22'd0;
                    cnt_d = 4'd0;
                end
            end
            MUL: begin
                if (sig_q[cnt_q]) acc_d = acc_q + ({11'd0, sig_q} << cnt_q);
                cnt_d = cnt_q + 4'd1;
            end
            NORM: begin
                out_d  = sq_result(acc_q[21:9], exp_q, sig_q[9:0]);
                done_d = 1'b1;
                busy_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 4'd0;
            sig_q  <= 11'd0;
            exp_q  <= 5'd0;
            acc_q  <= 22'd0;
            out_q  <= 16'h0000;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sig_q  <= sig_d;
            exp_q  <= exp_d;
            acc_q  <= acc_d;
            out_q  <= out_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
